fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch controller for a dual-issue front end: sequences the pair of PCs
// through reset, normal fetch, back-pressure stalls and post-redirect
// bubbles. Redirect outputs are Mealy so the PCs load the target on the
// same edge the branch resolves.
module fetch_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic        br_valid_1,
    input  logic        br_taken_1,
    input  logic [31:0] br_target_1,
    input  logic        br_valid_2,
    input  logic        br_taken_2,
    input  logic [31:0] br_target_2,
    output logic        pc_hold_1,
    output logic        pc_hold_2,
    output logic        pc_sel_1,
    output logic        pc_sel_2,
    output logic        read_en_1,
    output logic        read_en_2,
    output logic [31:0] jump_target,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] rcnt_q, rcnt_d;

    logic        lane1_tk, lane2_tk, redir;
    logic        pc_hold, pc_sel, read_en;

    // Redirect detection, next-state and Mealy output decode.
    always_comb begin
        lane1_tk    = br_valid_1 & br_taken_1;
        lane2_tk    = br_valid_2 & br_taken_2;
        // Branch resolution is meaningless before the first real fetch.
        redir       = (state_q != INIT) & (lane1_tk | lane2_tk);

        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        pc_hold     = 1'b1;
        pc_sel      = 1'b0;
        read_en     = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        jump_target = 32'h0;

        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN, STALL: begin
                read_en     = 1'b1;
                fetch_valid = 1'b1;
                pc_hold     = stall_req;
                state_d     = stall_req ? STALL : RUN;
            end
            FLUSH: begin
                // Bubbles keep fetching sequentially; stall_req is not
                // honoured until the last bubble.
                read_en = 1'b0 | 1'b1;
                pc_hold = 1'b0;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = stall_req ? STALL : RUN;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: state_d = INIT;
        endcase

        // A taken branch beats stall and restarts the bubble window.
        if (redir) begin
            pc_sel      = 1'b1;
            pc_hold     = 1'b0;
            flush       = 1'b1;
            read_en     = 1'b1;
            jump_target = lane1_tk ? {br_target_1[31:2], 2'b00}
                                   : {br_target_2[31:2], 2'b00};
            rcnt_d      = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
            if (FLUSH_CYCLES == 0) begin
                cnt_d   = 3'd0;
                state_d = stall_req ? STALL : RUN;
            end else begin
                cnt_d   = FLUSH_LOAD;
                state_d = FLUSH;
            end
        end
    end

    // State, bubble counter and redirect counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= 3'd0;
            rcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Both lanes share one PC policy.
    assign pc_hold_1      = pc_hold;
    assign pc_hold_2      = pc_hold;
    assign pc_sel_1       = pc_sel;
    assign pc_sel_2       = pc_sel;
    assign read_en_1      = read_en;
    assign read_en_2      = read_en;
    assign redirect_count = rcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one instance with a single bubble cycle,
// one with three, sharing clock and reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_stall, a_v1, a_t1, a_v2, a_t2;
    logic [31:0] a_tg1, a_tg2;
    logic        a_ph1, a_ph2, a_ps1, a_ps2, a_re1, a_re2, a_fv, a_fl;
    logic [31:0] a_jt;
    logic [15:0] a_rc;

    logic        b_stall, b_v1, b_t1, b_v2, b_t2;
    logic [31:0] b_tg1, b_tg2;
    logic        b_ph1, b_ph2, b_ps1, b_ps2, b_re1, b_re2, b_fv, b_fl;
    logic [31:0] b_jt;
    logic [15:0] b_rc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_req(a_stall),
        .br_valid_1(a_v1), .br_taken_1(a_t1), .br_target_1(a_tg1),
        .br_valid_2(a_v2), .br_taken_2(a_t2), .br_target_2(a_tg2),
        .pc_hold_1(a_ph1), .pc_hold_2(a_ph2), .pc_sel_1(a_ps1), .pc_sel_2(a_ps2),
        .read_en_1(a_re1), .read_en_2(a_re2), .jump_target(a_jt),
        .fetch_valid(a_fv), .flush(a_fl), .redirect_count(a_rc)
    );

    fetch_ctrl #(.FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_req(b_stall),
        .br_valid_1(b_v1), .br_taken_1(b_t1), .br_target_1(b_tg1),
        .br_valid_2(b_v2), .br_taken_2(b_t2), .br_target_2(b_tg2),
        .pc_hold_1(b_ph1), .pc_hold_2(b_ph2), .pc_sel_1(b_ps1), .pc_sel_2(b_ps2),
        .read_en_1(b_re1), .read_en_2(b_re2), .jump_target(b_jt),
        .fetch_valid(b_fv), .flush(b_fl), .redirect_count(b_rc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed control word {pc_hold, pc_sel, read_en, fetch_valid, flush},
    // with lane-2 copies required to equal lane 1.
    task automatic chk_a(input string tag, input logic [4:0] exp);
        chk({tag, ".ctl"}, {27'd0, a_ph1, a_ps1, a_re1, a_fv, a_fl}, {27'd0, exp});
        chk({tag, ".lane2"}, {29'd0, a_ph2, a_ps2, a_re2}, {29'd0, exp[4:2]});
    endtask

    task automatic chk_b(input string tag, input logic [4:0] exp);
        chk({tag, ".ctl"}, {27'd0, b_ph1, b_ps1, b_re1, b_fv, b_fl}, {27'd0, exp});
        chk({tag, ".lane2"}, {29'd0, b_ph2, b_ps2, b_re2}, {29'd0, exp[4:2]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        a_stall = 0; a_v1 = 0; a_t1 = 0; a_v2 = 0; a_t2 = 0; a_tg1 = 0; a_tg2 = 0;
    endtask

    task automatic clr_b();
        b_stall = 0; b_v1 = 0; b_t1 = 0; b_v2 = 0; b_t2 = 0; b_tg1 = 0; b_tg2 = 0;
    endtask

    // ctl encodings: {hold, sel, rd, fv, flush}
    localparam logic [4:0] C_INIT  = 5'b10000;
    localparam logic [4:0] C_RUN   = 5'b00110;
    localparam logic [4:0] C_HOLD  = 5'b10110;
    localparam logic [4:0] C_FLUSH = 5'b00100;
    localparam logic [4:0] C_RED_R = 5'b01111; // redirect from RUN/STALL
    localparam logic [4:0] C_RED_F = 5'b01101; // redirect from FLUSH

    initial begin
        rst_n = 1'b0;
        clr_a();
        clr_b();
        #1;
        chk_a("reset", C_INIT);
        chk("reset.jt", a_jt, 32'h0);
        chk("reset.rc", {16'd0, a_rc}, 32'h0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk_a("init", C_INIT);
        step();
        chk_a("run0", C_RUN);
        chk_b("b.run0", C_RUN);
        step();
        chk_a("run1", C_RUN);

        // Both lanes taken: lane 1 wins.
        a_v1 = 1; a_t1 = 1; a_tg1 = 32'h0040_0020;
        a_v2 = 1; a_t2 = 1; a_tg2 = 32'h0040_0100;
        #1;
        chk_a("redir1", C_RED_R);
        chk("redir1.jt", a_jt, 32'h0040_0020);
        chk("redir1.rc_pre", {16'd0, a_rc}, 32'd0);
        step();
        clr_a();
        #1;
        chk_a("flush1", C_FLUSH);
        chk("flush1.jt", a_jt, 32'h0);
        chk("flush1.rc", {16'd0, a_rc}, 32'd1);
        step();
        chk_a("run_after_flush", C_RUN);

        // Three stall cycles, then PCs advance.
        a_stall = 1;
        #1;
        chk_a("stall_c1", C_HOLD);
        step();
        chk_a("stall_c2", C_HOLD);
        step();
        chk_a("stall_c3", C_HOLD);
        step();
        a_stall = 0;
        #1;
        chk_a("stall_release", C_RUN);
        step();
        chk_a("run_after_stall", C_RUN);

        // Taken-not-valid and valid-not-taken are not redirects.
        a_v1 = 0; a_t1 = 1; a_tg1 = 32'h1234_5678;
        a_v2 = 1; a_t2 = 0; a_tg2 = 32'h0bad_0000;
        #1;
        chk_a("no_redir", C_RUN);
        chk("no_redir.jt", a_jt, 32'h0);
        clr_a();

        // Lane-2 redirect during STALL, misaligned target.
        a_stall = 1;
        step();
        a_v2 = 1; a_t2 = 1; a_tg2 = 32'h0040_0013;
        a_v1 = 1; a_t1 = 0; a_tg1 = 32'h0000_0abc;
        #1;
        chk_a("stall_redir", C_RED_R);
        chk("stall_redir.jt", a_jt, 32'h0040_0010);
        step();
        a_v1 = 0; a_v2 = 0; a_t2 = 0;
        #1;
        chk_a("flush_ign_stall", C_FLUSH);
        chk("flush2.rc", {16'd0, a_rc}, 32'd2);
        step();
        chk_a("flush_exit_stall", C_HOLD);
        a_stall = 0;
        #1;
        chk_a("stall_rel2", C_RUN);
        step();
        chk_a("run2", C_RUN);

        // Three-bubble instance: redirect, second redirect in 2nd bubble.
        b_v1 = 1; b_t1 = 1; b_tg1 = 32'h0000_1000;
        #1;
        chk_b("b.redir1", C_RED_R);
        step();
        clr_b();
        #1;
        chk_b("b.fl1", C_FLUSH);
        step();
        b_v2 = 1; b_t2 = 1; b_tg2 = 32'h0000_2002;
        #1;
        chk_b("b.redir2", C_RED_F);
        chk("b.redir2.jt", b_jt, 32'h0000_2000);
        step();
        clr_b();
        #1;
        chk_b("b.fl_a", C_FLUSH);
        chk("b.rc", {16'd0, b_rc}, 32'd2);
        step();
        chk_b("b.fl_b", C_FLUSH);
        step();
        chk_b("b.fl_c", C_FLUSH);
        step();
        chk_b("b.run", C_RUN);

        // Reset mid-FLUSH takes effect without a clock edge.
        b_v1 = 1; b_t1 = 1; b_tg1 = 32'h0000_3000;
        step();
        clr_b();
        #1;
        chk_b("b.fl_pre_rst", C_FLUSH);
        chk("b.rc3", {16'd0, b_rc}, 32'd3);
        #1;
        rst_n = 1'b0;
        b_v1 = 1; b_t1 = 1; b_tg1 = 32'h0000_4000;
        #1;
        chk_b("b.async_rst", C_INIT);
        chk("b.async_rst.jt", b_jt, 32'h0);
        chk("b.async_rst.rc", {16'd0, b_rc}, 32'd0);
        clr_b();
        step();
        rst_n = 1'b1;
        #1;
        chk_b("b.init2", C_INIT);
        step();
        chk_b("b.run_after_rst", C_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
